// File: rtl/imm_narrower.sv
// imm_narrower: packs a wide value into the narrow immediate field.
// Two-stage valid/ready pipeline. Stage 1 holds the raw beat and evaluates the
// range check. Stage 2 holds the narrowed immediate and its overflow flag.
// The overflow counter counts only overflowed beats that are delivered.
module imm_narrower #(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned OUT_W = 24,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             signop,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             clr_count
);

    logic                  s1_valid;
    logic [IN_W-1:0]       s1_data;
    logic                  s1_signop;
    logic                  s1_sat;
    logic                  s1_advance;
    logic                  s2_advance;
    logic                  fit;
    logic [OUT_W-1:0]      res_data;
    logic [IN_W-OUT_W:0]   sgn_bits;
    logic [IN_W-OUT_W-1:0] uns_bits;

    // Stage 2 moves when it is empty or its beat is taken downstream.
    // Stage 1 hands its beat to stage 2 whenever stage 2 moves.
    assign s2_advance = !out_valid || out_ready;
    assign s1_advance = s2_advance;
    assign in_ready   = !s1_valid || s1_advance;

    // Range check and truncate/saturate on the stage-1 beat.
    always_comb begin
        sgn_bits = s1_data[IN_W-1:OUT_W-1];
        uns_bits = s1_data[IN_W-1:OUT_W];
        if (s1_signop) begin
            fit = (&sgn_bits) || (~|sgn_bits);
        end else begin
            fit = ~|uns_bits;
        end
        res_data = s1_data[OUT_W-1:0];
        if (!fit && s1_sat) begin
            if (s1_signop) begin
                res_data = s1_data[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                           : {1'b0, {(OUT_W-1){1'b1}}};
            end else begin
                res_data = '1;
            end
        end
    end

    // Stage 1 register: captures the incoming beat and its mode bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_signop <= 1'b0;
            s1_sat    <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data   <= in_data;
                s1_signop <= signop;
                s1_sat    <= sat_en;
            end
        end
    end

    // Stage 2 register: narrowed immediate, held while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else if (s2_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= res_data;
                out_ovf  <= !fit;
            end
        end
    end

    // Saturating overflow counter; clear takes priority over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count <= '0;
        end else if (clr_count) begin
            ovf_count <= '0;
        end else if (out_valid && out_ready && out_ovf && (ovf_count != '1)) begin
            ovf_count <= ovf_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_imm_narrower.sv
// Directed and random bench for imm_narrower.
module tb_imm_narrower;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        signop;
    logic        sat_en;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic        out_ovf;
    logic [7:0]  ovf_count;
    logic        clr_count;

    int unsigned checks;
    int unsigned errors;
    int unsigned exp_cnt;

    imm_narrower #(
        .IN_W  (32),
        .OUT_W (24),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .signop    (signop),
        .sat_en    (sat_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .ovf_count (ovf_count),
        .clr_count (clr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, data} from numeric range comparisons.
    function automatic logic [24:0] model(input logic [31:0] d, input logic so, input logic sa);
        int  sd;
        logic fits;
        logic [23:0] r;
        sd = d;
        if (so) fits = (sd >= -8388608) && (sd <= 8388607);
        else    fits = (d <= 32'h00FF_FFFF);
        r = d[23:0];
        if (!fits && sa) begin
            if (so) r = (sd < 0) ? 24'h800000 : 24'h7FFFFF;
            else    r = 24'hFFFFFF;
        end
        return {!fits, r};
    endfunction

    // Single beat with out_ready high; checks latency, data and flag.
    task automatic one(input string tag, input logic [31:0] d, input logic so, input logic sa,
                       input logic [23:0] ed, input logic eo);
        @(negedge clk);
        in_valid = 1'b1; in_data = d; signop = so; sat_en = sa; out_ready = 1'b1;
        #1;
        check({tag, "_rdy"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_v0"}, out_valid, 0);
        @(posedge clk); #1;
        check({tag, "_v1"}, out_valid, 1);
        check({tag, "_data"}, out_data, ed);
        check({tag, "_ovf"}, out_ovf, eo);
        if (eo && exp_cnt < 255) exp_cnt++;
        @(posedge clk); #1;
    endtask

    logic [31:0] bvals [6];
    logic        bovf_s [6];
    logic        bovf_u [6];
    logic [31:0] got [$];
    logic [24:0] expq [$];
    logic [24:0] e;
    int unsigned idx;
    int unsigned guard;
    int unsigned seen;
    logic        acc;
    logic        xfer;
    logic [31:0] rd;

    initial begin
        checks = 0; errors = 0; exp_cnt = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; signop = 1'b0; sat_en = 1'b0;
        out_ready = 1'b0; clr_count = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_ovf_count", ovf_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);

        // Signed fit and round trip
        one("sfit", 32'hFFFF2609, 1, 0, 24'hFF2609, 0);
        @(negedge clk);
        one("sfit_sat", 32'hFFFF2609, 1, 1, 24'hFF2609, 0);

        // Overflow modes
        one("ovf_sat", 32'h00FF2609, 1, 1, 24'h7FFFFF, 1);
        one("ovf_trunc", 32'h00FF2609, 1, 0, 24'hFF2609, 1);
        one("uns_fit", 32'h00FF2609, 0, 1, 24'hFF2609, 0);
        one("neg_sat", 32'h80000000, 1, 1, 24'h800000, 1);

        // Boundaries in both modes, truncating
        bvals  = '{32'h007FFFFF, 32'h00800000, 32'hFF800000, 32'hFF7FFFFF, 32'h00FFFFFF, 32'h01000000};
        bovf_s = '{0, 1, 0, 1, 1, 1};
        bovf_u = '{0, 0, 1, 1, 0, 1};
        for (int unsigned i = 0; i < 6; i++) begin
            rd = bvals[i];
            one($sformatf("bnd_s%0d", i), rd, 1, 0, rd[23:0], bovf_s[i]);
            one($sformatf("bnd_u%0d", i), rd, 0, 0, rd[23:0], bovf_u[i]);
        end
        one("uns_sat", 32'h01000000, 0, 1, 24'hFFFFFF, 1);
        check("cnt_directed", ovf_count, exp_cnt);

        // Backpressure: two beats held, input stalls, head stays stable
        @(negedge clk);
        out_ready = 1'b0; idx = 1;
        for (int unsigned c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = (idx <= 4); in_data = idx; signop = 1'b0; sat_en = 1'b0;
            #1;
            if (c >= 2) begin
                check("bp_stall", in_ready, 0);
                check("bp_hold_v", out_valid, 1);
                check("bp_hold_d", out_data, 24'h000001);
            end else begin
                check("bp_early_rdy", in_ready, 1);
            end
            if (in_valid && in_ready) idx++;
        end
        got.delete();
        guard = 0;
        while (got.size() < 4 && guard < 20) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid = (idx <= 4); in_data = idx;
            #1;
            if (out_valid) got.push_back({8'h00, out_data});
            if (in_valid && in_ready) idx++;
            @(posedge clk);
            guard++;
        end
        in_valid = 1'b0;
        check("bp_count", got.size(), 4);
        for (int unsigned i = 0; i < got.size() && i < 4; i++)
            check($sformatf("bp_order%0d", i), got[i], i + 1);
        @(negedge clk); #1;
        check("bp_no_dup", out_valid, 0);

        // Random traffic against the reference model
        @(negedge clk);
        clr_count = 1'b1;
        @(negedge clk);
        clr_count = 1'b0;
        exp_cnt = 0;
        expq.delete();
        for (int unsigned c = 0; c < 1000; c++) begin
            @(negedge clk);
            rd = $urandom;
            case ($urandom_range(0, 2))
                0:       rd = {{8{rd[23]}}, rd[23:0]};
                1:       rd = {8'h00, rd[23:0]};
                default: ;
            endcase
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = rd;
            signop    = $urandom_range(0, 1);
            sat_en    = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc  = in_valid && in_ready;
            xfer = out_valid && out_ready;
            if (xfer) begin
                if (expq.size() == 0) begin
                    check("rnd_spurious", out_valid, 0);
                end else begin
                    e = expq.pop_front();
                    check("rnd_data", out_data, e[23:0]);
                    check("rnd_ovf", out_ovf, e[24]);
                    if (e[24] && exp_cnt < 255) exp_cnt++;
                end
            end
            if (acc) expq.push_back(model(in_data, signop, sat_en));
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        guard = 0;
        while (expq.size() > 0 && guard < 10) begin
            #1;
            if (out_valid) begin
                e = expq.pop_front();
                check("rnd_drain_data", out_data, e[23:0]);
                check("rnd_drain_ovf", out_ovf, e[24]);
                if (e[24] && exp_cnt < 255) exp_cnt++;
            end
            @(negedge clk);
            guard++;
        end
        check("rnd_left", expq.size(), 0);
        check("rnd_cnt", ovf_count, exp_cnt);

        // Counter saturation: 260 overflowing beats
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'h01000000; signop = 1'b0; sat_en = 1'b1; out_ready = 1'b1;
        repeat (260) @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("cnt_sat", ovf_count, 255);

        // Clear concurrent with an overflow transfer
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h00800000; signop = 1'b1; sat_en = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("clr_wait", out_valid, 1);
        out_ready = 1'b1; clr_count = 1'b1;
        @(posedge clk); #1;
        clr_count = 1'b0;
        check("clr_wins", ovf_count, 0);
        check("clr_xfer", out_valid, 0);

        // Reset with two beats in flight
        one("pre_rst", 32'h00800000, 1, 0, 24'h800000, 1);
        check("pre_rst_cnt", ovf_count, 1);
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h00000011; signop = 1'b0; sat_en = 1'b0;
        @(negedge clk);
        in_data = 32'h00000022;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("inflight_v", out_valid, 1);
        check("inflight_rdy", in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_ovf_count", ovf_count, 0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        seen = 0;
        for (int unsigned c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            if (out_valid) seen++;
        end
        check("no_stale", seen, 0);
        check("post_rst_rdy", in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
